wb_write_scheduler: RTL and testbench

//  Write-back scheduler between MEM/WB and the dual-write-port register file.

---
 rtl/wb_write_scheduler_if.sv | 46 ++++
 rtl/wb_write_scheduler.sv | 109 ++++++++++
 tb/tb_wb_write_scheduler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_scheduler_if.sv
// Write-back scheduler bus: MEM/WB result pair in, register-file ports,
// bypass lookup and scoreboard out.
interface wb_write_scheduler_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              InValidA;
  logic [ADDR_W-1:0] InRegA;
  logic [DATA_W-1:0] InDataA;
  logic              InValidB;
  logic [ADDR_W-1:0] InRegB;
  logic [DATA_W-1:0] InDataB;
  logic              InReady;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              WriteEn2;
  logic [ADDR_W-1:0] WriteRegister2;
  logic [DATA_W-1:0] WriteData2;
  logic [ADDR_W-1:0] LookupReg;
  logic              LookupHit;
  logic [DATA_W-1:0] LookupData;
  logic [31:0]       Pending;
  logic [CW-1:0]     Count;

  modport master (
    output InValidA, InRegA, InDataA,
    output InValidB, InRegB, InDataB,
    output LookupReg,
    input  InReady, RegWrite, WriteRegister, WriteData,
    input  WriteEn2, WriteRegister2, WriteData2,
    input  LookupHit, LookupData, Pending, Count
  );

  modport slave (
    input  InValidA, InRegA, InDataA,
    input  InValidB, InRegB, InDataB,
    input  LookupReg,
    output InReady, RegWrite, WriteRegister, WriteData,
    output WriteEn2, WriteRegister2, WriteData2,
    output LookupHit, LookupData, Pending, Count
  );
endinterface

// File: rtl/wb_write_scheduler.sv
// In-order dual-push / dual-drain write-back FIFO with pending
// scoreboard and newest-value bypass lookup.
module wb_write_scheduler #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  wb_write_scheduler_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] reg_q [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     sec_ptr;
  logic [PW-1:0]     b_ptr;
  logic [CW-1:0]     cnt_q;
  logic              ready;
  logic              en1;
  logic              en2;
  logic              push_a;
  logic              push_b;
  logic [1:0]        n_push;
  logic [1:0]        n_pop;
  logic [31:0]       pend;
  logic              hit;
  logic [DATA_W-1:0] hit_dat;
  logic [PW-1:0]     idx;

  assign ready   = cnt_q <= CW'(DEPTH - 2);
  assign sec_ptr = rd_ptr + PW'(1);
  assign en1     = cnt_q != '0;
  // Same-destination pair would race in the register file: hold the younger.
  assign en2     = (cnt_q >= CW'(2)) &&
                   (reg_q[sec_ptr] != reg_q[rd_ptr]);

  assign push_a = ready && bus.InValidA && (bus.InRegA != '0);
  assign push_b = ready && bus.InValidB && (bus.InRegB != '0);
  assign b_ptr  = wr_ptr + PW'(push_a);
  assign n_push = {1'b0, push_a} + {1'b0, push_b};
  assign n_pop  = {1'b0, en1} + {1'b0, en2};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      if (en1)    vld_q[rd_ptr]  <= 1'b0;
      if (en2)    vld_q[sec_ptr] <= 1'b0;
      if (push_a) vld_q[wr_ptr]  <= 1'b1;
      if (push_b) vld_q[b_ptr]   <= 1'b1;
      rd_ptr <= rd_ptr + PW'(n_pop);
      wr_ptr <= wr_ptr + PW'(n_push);
      cnt_q  <= cnt_q + CW'(n_push) - CW'(n_pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (push_a) begin
      reg_q[wr_ptr] <= bus.InRegA;
      dat_q[wr_ptr] <= bus.InDataA;
    end
    if (push_b) begin
      reg_q[b_ptr] <= bus.InRegB;
      dat_q[b_ptr] <= bus.InDataB;
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i]) pend[reg_q[i]] = 1'b1;
    pend[0] = 1'b0;
  end

  // Walk oldest to youngest so the last match is the newest value.
  always_comb begin
    hit     = 1'b0;
    hit_dat = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (vld_q[idx] && (reg_q[idx] == bus.LookupReg) &&
          (bus.LookupReg != '0)) begin
        hit     = 1'b1;
        hit_dat = dat_q[idx];
      end
    end
  end

  assign bus.InReady        = ready;
  assign bus.RegWrite       = en1;
  assign bus.WriteRegister  = en1 ? reg_q[rd_ptr] : '0;
  assign bus.WriteData      = en1 ? dat_q[rd_ptr] : '0;
  assign bus.WriteEn2       = en2;
  assign bus.WriteRegister2 = en2 ? reg_q[sec_ptr] : '0;
  assign bus.WriteData2     = en2 ? dat_q[sec_ptr] : '0;
  assign bus.LookupHit      = hit;
  assign bus.LookupData     = hit_dat;
  assign bus.Pending        = pend;
  assign bus.Count          = cnt_q;
endmodule

// File: tb/tb_wb_write_scheduler.sv
// Bench for wb_write_scheduler: queue model checked every negedge
// plus directed literal expectations.
module tb_wb_write_scheduler;
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wb_write_scheduler_if #(.DEPTH(8), .DATA_W(32), .ADDR_W(5)) ifc ();

  wb_write_scheduler #(.DEPTH(8), .DATA_W(32), .ADDR_W(5)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (ifc.slave)
  );

  always #5 Clk = ~Clk;

  wr_t mq[$];
  wr_t plog[$];
  wr_t ilog[$];
  bit  acc;
  bit  saw_full;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Queue model: drain oldest (and next if its dest differs), then accept.
  int m_sz;
  int m_np;
  bit m_rdy;
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mq.delete();
      acc = 1'b0;
    end else begin
      m_sz  = mq.size();
      m_rdy = (m_sz <= 6);
      m_np  = (m_sz == 0) ? 0 :
              ((m_sz >= 2 && mq[1].r != mq[0].r) ? 2 : 1);
      repeat (m_np) void'(mq.pop_front());
      acc = m_rdy;
      if (m_rdy && ifc.InValidA && ifc.InRegA != 0) begin
        mq.push_back('{ifc.InRegA, ifc.InDataA});
        plog.push_back('{ifc.InRegA, ifc.InDataA});
      end
      if (m_rdy && ifc.InValidB && ifc.InRegB != 0) begin
        mq.push_back('{ifc.InRegB, ifc.InDataB});
        plog.push_back('{ifc.InRegB, ifc.InDataB});
      end
    end
  end

  logic [31:0] e_pend;
  logic        e_hit;
  logic [31:0] e_ld;
  bit          e_en2;
  always @(negedge Clk) begin
    e_pend = '0;
    foreach (mq[i]) e_pend[mq[i].r] = 1'b1;
    e_hit = 1'b0;
    e_ld  = '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (!e_hit && ifc.LookupReg != 0 && mq[i].r == ifc.LookupReg) begin
        e_hit = 1'b1;
        e_ld  = mq[i].d;
      end
    e_en2 = mq.size() >= 2 && mq[1].r != mq[0].r;
    chk("count", ifc.Count, mq.size());
    chk("inready", ifc.InReady, mq.size() <= 6);
    chk("regwrite", ifc.RegWrite, mq.size() >= 1);
    chk("wen2", ifc.WriteEn2, e_en2);
    if (mq.size() >= 1) begin
      chk("wreg1", ifc.WriteRegister, mq[0].r);
      chk("wdat1", ifc.WriteData, mq[0].d);
    end
    if (e_en2) begin
      chk("wreg2", ifc.WriteRegister2, mq[1].r);
      chk("wdat2", ifc.WriteData2, mq[1].d);
    end
    chk("pending", ifc.Pending, e_pend);
    chk("lkhit", ifc.LookupHit, e_hit);
    chk("lkdata", ifc.LookupData, e_ld);
    if (Rst_n && ifc.RegWrite)
      ilog.push_back('{ifc.WriteRegister, ifc.WriteData});
    if (Rst_n && ifc.WriteEn2)
      ilog.push_back('{ifc.WriteRegister2, ifc.WriteData2});
  end

  task automatic drive(bit va, logic [4:0] ra, logic [31:0] da,
                       bit vb, logic [4:0] rb, logic [31:0] db);
    ifc.InValidA = va; ifc.InRegA = ra; ifc.InDataA = da;
    ifc.InValidB = vb; ifc.InRegB = rb; ifc.InDataB = db;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge Clk);
    #1;
  endtask

  initial begin
    int k;
    idle();
    ifc.LookupReg = '0;
    repeat (2) tick();
    Rst_n = 1'b1;
    at_neg();
    chk("rst_count", ifc.Count, 0);
    chk("rst_ready", ifc.InReady, 1);
    chk("rst_we", ifc.RegWrite, 0);
    chk("rst_pend", ifc.Pending, 0);
    tick();

    // 1) single result
    drive(1, 5, 32'h11, 0, 0, 0);
    tick(); idle();
    at_neg();
    chk("t1_we", ifc.RegWrite, 1);
    chk("t1_reg", ifc.WriteRegister, 5);
    chk("t1_dat", ifc.WriteData, 32'h11);
    chk("t1_we2", ifc.WriteEn2, 0);
    chk("t1_cnt", ifc.Count, 1);
    chk("t1_pend", ifc.Pending, 32'h20);
    tick();
    at_neg();
    chk("t1_cnt0", ifc.Count, 0);
    tick();

    // 2) dual issue
    drive(1, 3, 32'hA, 1, 4, 32'hB);
    tick(); idle();
    at_neg();
    chk("t2_reg1", ifc.WriteRegister, 3);
    chk("t2_dat1", ifc.WriteData, 32'hA);
    chk("t2_we2", ifc.WriteEn2, 1);
    chk("t2_reg2", ifc.WriteRegister2, 4);
    chk("t2_dat2", ifc.WriteData2, 32'hB);
    tick();
    at_neg();
    chk("t2_cnt0", ifc.Count, 0);
    tick();

    // 3) same-destination conflict and bypass
    ifc.LookupReg = 7;
    drive(1, 7, 1, 1, 7, 2);
    tick(); idle();
    at_neg();
    chk("t3_dat1", ifc.WriteData, 1);
    chk("t3_we2", ifc.WriteEn2, 0);
    chk("t3_lk2", ifc.LookupData, 2);
    chk("t3_cnt", ifc.Count, 2);
    tick();
    at_neg();
    chk("t3_dat1b", ifc.WriteData, 2);
    chk("t3_lk1", ifc.LookupData, 2);
    chk("t3_cnt1", ifc.Count, 1);
    tick();
    at_neg();
    chk("t3_nohit", ifc.LookupHit, 0);
    tick();

    // 4) r0 dropped
    ifc.LookupReg = 0;
    drive(1, 0, 32'h55, 1, 9, 32'h66);
    tick(); idle();
    at_neg();
    chk("t4_cnt", ifc.Count, 1);
    chk("t4_pend", ifc.Pending, 32'h200);
    chk("t4_reg", ifc.WriteRegister, 9);
    tick(); tick();

    // 5) saturation with same-dest pairs, across pointer wrap
    plog.delete();
    ilog.delete();
    saw_full = 1'b0;
    ifc.LookupReg = 6;
    k = 0;
    for (int c = 0; c < 200 && k < 20; c++) begin
      drive(1, 6, 100 + 2 * k, 1, 6, 101 + 2 * k);
      tick();
      if (acc) k++;
      if (ifc.Count == 7 && !ifc.InReady) saw_full = 1'b1;
    end
    idle();
    for (int c = 0; c < 40 && ifc.Count != 0; c++) tick();
    at_neg();
    chk("t5_drained", ifc.Count, 0);
    chk("t5_full", saw_full, 1);
    chk("t5_pushes", plog.size(), 40);
    chk("t5_issues", ilog.size(), plog.size());
    for (int i = 0; i < plog.size() && i < ilog.size(); i++)
      chk("t5_order", ilog[i], plog[i]);
    tick();

    // 6) asynchronous reset with 5 queued
    for (int c = 0; c < 4; c++) begin
      drive(1, 8, c * 2, 1, 8, c * 2 + 1);
      tick();
    end
    idle();
    at_neg();
    chk("t6_cnt5", ifc.Count, 5);
    #2 Rst_n = 1'b0;
    #1;
    chk("t6_cnt", ifc.Count, 0);
    chk("t6_we", ifc.RegWrite, 0);
    chk("t6_we2", ifc.WriteEn2, 0);
    chk("t6_pend", ifc.Pending, 0);
    repeat (2) tick();
    at_neg();
    #2 Rst_n = 1'b1;
    drive(1, 12, 32'h77, 0, 0, 0);
    tick(); idle();
    at_neg();
    chk("t6_after", ifc.WriteRegister, 12);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
